rat_io_ctrl: RTL and testbench
==============================

// Module: rat_io_ctrl
// PURPOSE
//  Parametrised port-mapped I/O controller between the RAT MCU port bus (PORT_ID/OUT_PORT/IN_PORT/IO_STRB)
//  and board peripherals. Holds N_OUT writable output registers with write pulses and N_IN synchronised
//  input ports. Adds a maskable N_IRQ-source interrupt controller with edge capture, W1C acknowledge and
//  an INTERRUPT pulse FSM. Replaces per-board hand-coded in/out muxes inside the wrapper.
// PARAMETERS
//  DATA_W      8      port data width (N_IRQ <= DATA_W)
//  N_OUT       4      output registers, IDs OUT_BASE..OUT_BASE+N_OUT-1
//  N_IN        4      input ports, IDs IN_BASE..IN_BASE+N_IN-1
//  N_IRQ       4      interrupt sources
//  OUT_BASE    8'h40  first output port ID
//  IN_BASE     8'h20  first input port ID
//  IRQ_MASK_ID 8'hF0  mask register (R/W)
//  IRQ_PEND_ID 8'hF1  pending register (read-only)
//  IRQ_ACK_ID  8'hF2  acknowledge (write-1-to-clear pending)
//  SYNC_STAGES 2      synchroniser depth for DEV_IN and IRQ_SRC (>=2)
// PORTS
//  CLK      in   1            system clock (MCU clock)
//  RESET_N  in   1            synchronous, active-low reset
//  PORT_ID  in   8            MCU port address
//  OUT_PORT in   DATA_W       MCU write data
//  IO_STRB  in   1            MCU write strobe, one cycle
//  IN_PORT  out  DATA_W       MCU read data (combinational)
//  DEV_IN   in   N_IN*DATA_W  raw async peripheral inputs, port k at [k*DATA_W +: DATA_W]
//  DEV_OUT  out  N_OUT*DATA_W output registers, same packing
//  DEV_WR   out  N_OUT        one-cycle pulse per register written
//  IRQ_SRC  in   N_IRQ        raw async interrupt requests (debounced externally)
//  INTERRUPT out 1            one-cycle interrupt pulse to MCU
// BEHAVIOUR
//  Reset (RESET_N=0 at CLK edge): DEV_OUT=0, DEV_WR=0, mask=0, pending=0, all sync/edge flops=0,
//   FSM=IRQ_IDLE, INTERRUPT=0. Reset mid-write discards the write. Reset dominates all other events.
//  Write: IO_STRB=1 & PORT_ID==OUT_BASE+k -> next edge DEV_OUT[k]<=OUT_PORT, DEV_WR[k]=1 for that cycle only.
//   PORT_ID==IRQ_MASK_ID -> mask<=OUT_PORT[N_IRQ-1:0]. PORT_ID==IRQ_ACK_ID -> pending&=~OUT_PORT[N_IRQ-1:0].
//   Unmapped IDs: no state change. Bits above N_IRQ ignored.
//  Read (0 latency): IN_BASE+k -> synced DEV_IN[k]; OUT_BASE+k -> DEV_OUT[k] readback;
//   IRQ_MASK_ID/IRQ_PEND_ID -> zero-extended mask/pending; else 0.
//  Input sync: DEV_IN change visible on IN_PORT exactly SYNC_STAGES edges later.
//  IRQ capture: synced IRQ_SRC[i] 0->1 (vs registered previous value) sets pending[i] next edge,
//   regardless of mask. Set and ack of same bit in same cycle: set wins (pending stays 1).
//   Source high through reset release is seen as a rising edge (pending after SYNC_STAGES+1 edges).
//  active = |(pending & mask). INTERRUPT FSM (registered output):
//   IRQ_IDLE: active -> IRQ_FIRE.
//   IRQ_FIRE: INTERRUPT=1 for this one cycle; -> IRQ_WAIT.
//   IRQ_WAIT: active==0 -> IRQ_IDLE; ack write leaving active!=0 (after update) -> IRQ_FIRE; else stay.
//   New sources arriving in IRQ_WAIT do not re-pulse until an ack write or return to IDLE.
//   Mask write clearing all active bits in IRQ_WAIT -> IRQ_IDLE.
//  Elaboration $error if ID ranges overlap, N_IRQ>DATA_W, or SYNC_STAGES<2.
// STRUCTURE
//  Package rat_io_pkg: typedef enum logic[1:0] {IRQ_IDLE,IRQ_FIRE,IRQ_WAIT} irq_state_t;
//   default port-ID localparams (SWITCHES_ID 8'h20, LEDS_ID 8'h40, SEG_ID 8'h81, IRQ IDs F0-F2).
//  Sub-module rat_sync #(WIDTH,STAGES): reset-to-0 multi-flop synchroniser, instanced for DEV_IN and IRQ_SRC.
// TESTING
//  1 Write 8'hA5 to 8'h41 with IO_STRB -> DEV_OUT[1]=A5 next edge, DEV_WR=4'b0010 one cycle; read 8'h41 -> A5.
//  2 DEV_IN[0]=8'h3C at edge t -> IN_PORT at PORT_ID 8'h20 reads 3C from edge t+2, 00 before; 8'h99 reads 00.
//  3 mask=4'b0001, pulse IRQ_SRC[0] -> pending=1, INTERRUPT single 1-cycle pulse; no second pulse while held.
//  4 pending 4'b0011 mask 4'b0011, ack 8'h01 -> pending=0010, INTERRUPT re-pulses; ack 8'h02 -> IDLE, no pulse.
//  5 Rising edge on IRQ_SRC[2] in same cycle as ack 8'h04 -> pending[2] remains 1.
//  6 RESET_N=0 during IO_STRB write to 8'h40 and with pending set -> all outputs/regs 0, no DEV_WR, FSM IDLE.

Source files
------------

// File: rtl/rat_io_pkg.sv
// ---------------------------------------------------------------------------
// rat_io_pkg
// Shared types and default port IDs for the RAT MCU port-mapped I/O block.
//   irq_state_t      : interrupt pulse FSM encoding (also exposed for debug)
//   *_ID             : board-level default port IDs
//   ranges_overlap() : helper used by rat_io_ctrl to reject clashing ID maps
// ---------------------------------------------------------------------------
package rat_io_pkg;

    typedef enum logic [1:0] {
        IRQ_IDLE = 2'd0,
        IRQ_FIRE = 2'd1,
        IRQ_WAIT = 2'd2
    } irq_state_t;

    // Default board port map
    localparam logic [7:0] SWITCHES_ID     = 8'h20;
    localparam logic [7:0] LEDS_ID         = 8'h40;
    localparam logic [7:0] SEG_ID          = 8'h81;
    localparam logic [7:0] DEF_IRQ_MASK_ID = 8'hF0;
    localparam logic [7:0] DEF_IRQ_PEND_ID = 8'hF1;
    localparam logic [7:0] DEF_IRQ_ACK_ID  = 8'hF2;
    localparam int         DEF_SYNC_STAGES = 2;

    // True when ID window [a_lo, a_lo+a_n) intersects [b_lo, b_lo+b_n).
    function automatic bit ranges_overlap(input int a_lo, input int a_n,
                                          input int b_lo, input int b_n);
        return (a_lo < b_lo + b_n) && (b_lo < a_lo + a_n);
    endfunction

endpackage

// File: rtl/rat_sync.sv
// ---------------------------------------------------------------------------
// rat_sync
// Multi-flop synchroniser for asynchronous inputs. Every flop clears to 0 on
// reset, so a high input is re-seen as a 0->1 transition after reset release.
// Ports:
//   CLK      : destination clock
//   RESET_N  : synchronous active-low reset
//   D        : raw asynchronous input bus
//   Q        : synchronised output, STAGES edges behind D
// ---------------------------------------------------------------------------
module rat_sync #(
    parameter int WIDTH  = 1,
    parameter int STAGES = 2
) (
    input  logic             CLK,
    input  logic             RESET_N,
    input  logic [WIDTH-1:0] D,
    output logic [WIDTH-1:0] Q
);

    logic [STAGES-1:0][WIDTH-1:0] chain;

    always_ff @(posedge CLK) begin
        if (!RESET_N) begin
            chain <= '0;
        end else begin
            chain[0] <= D;
            for (int s = 1; s < STAGES; s++) begin
                chain[s] <= chain[s-1];
            end
        end
    end

    assign Q = chain[STAGES-1];

endmodule

// File: rtl/rat_io_ctrl.sv
// ---------------------------------------------------------------------------
// rat_io_ctrl
// Port-mapped I/O controller between the RAT MCU port bus and board
// peripherals: N_OUT writable output registers with write pulses, N_IN
// synchronised input ports, and an N_IRQ-source maskable interrupt
// controller (edge capture, write-1-to-clear ack, one-cycle INTERRUPT pulse).
// Ports:
//   CLK, RESET_N : clock, synchronous active-low reset
//   PORT_ID      : MCU port address
//   OUT_PORT     : MCU write data
//   IO_STRB      : MCU write strobe
//   IN_PORT      : MCU read data (combinational decode of PORT_ID)
//   DEV_IN       : raw async peripheral inputs, port k at [k*DATA_W +: DATA_W]
//   DEV_OUT      : output registers, same packing
//   DEV_WR       : one-cycle pulse per output register written
//   IRQ_SRC      : raw async interrupt requests
//   INTERRUPT    : one-cycle interrupt pulse to the MCU
//   IRQ_STATE    : current interrupt FSM state (debug visibility)
//
// Bus protocol: IO_STRB acts as a one-cycle valid with an implicit,
// always-asserted ready. A write is accepted at the edge where IO_STRB=1,
// using the PORT_ID/OUT_PORT present at that edge; there is no back-pressure.
// Reads have no strobe: IN_PORT follows PORT_ID combinationally.
// ---------------------------------------------------------------------------
module rat_io_ctrl
    import rat_io_pkg::*;
#(
    parameter int         DATA_W      = 8,
    parameter int         N_OUT       = 4,
    parameter int         N_IN        = 4,
    parameter int         N_IRQ       = 4,
    parameter logic [7:0] OUT_BASE    = LEDS_ID,
    parameter logic [7:0] IN_BASE     = SWITCHES_ID,
    parameter logic [7:0] IRQ_MASK_ID = DEF_IRQ_MASK_ID,
    parameter logic [7:0] IRQ_PEND_ID = DEF_IRQ_PEND_ID,
    parameter logic [7:0] IRQ_ACK_ID  = DEF_IRQ_ACK_ID,
    parameter int         SYNC_STAGES = DEF_SYNC_STAGES
) (
    input  logic                    CLK,
    input  logic                    RESET_N,
    input  logic [7:0]              PORT_ID,
    input  logic [DATA_W-1:0]       OUT_PORT,
    input  logic                    IO_STRB,
    output logic [DATA_W-1:0]       IN_PORT,
    input  logic [N_IN*DATA_W-1:0]  DEV_IN,
    output logic [N_OUT*DATA_W-1:0] DEV_OUT,
    output logic [N_OUT-1:0]        DEV_WR,
    input  logic [N_IRQ-1:0]        IRQ_SRC,
    output logic                    INTERRUPT,
    output irq_state_t              IRQ_STATE
);

    // -----------------------------------------------------------------------
    // Elaboration-time sanity checks on the port map and sizes
    // -----------------------------------------------------------------------
    localparam int OUT_LO  = int'(OUT_BASE);
    localparam int IN_LO   = int'(IN_BASE);
    localparam int MASK_ID = int'(IRQ_MASK_ID);
    localparam int PEND_ID = int'(IRQ_PEND_ID);
    localparam int ACK_ID  = int'(IRQ_ACK_ID);

    localparam bit ID_CLASH =
        ranges_overlap(OUT_LO, N_OUT, IN_LO, N_IN)   ||
        ranges_overlap(MASK_ID, 1, OUT_LO, N_OUT)    ||
        ranges_overlap(MASK_ID, 1, IN_LO, N_IN)      ||
        ranges_overlap(PEND_ID, 1, OUT_LO, N_OUT)    ||
        ranges_overlap(PEND_ID, 1, IN_LO, N_IN)      ||
        ranges_overlap(ACK_ID, 1, OUT_LO, N_OUT)     ||
        ranges_overlap(ACK_ID, 1, IN_LO, N_IN)       ||
        (MASK_ID == PEND_ID) || (MASK_ID == ACK_ID)  ||
        (PEND_ID == ACK_ID);

    if (ID_CLASH) begin : g_err_id_clash
        $error("rat_io_ctrl: port ID ranges overlap");
    end
    if (N_IRQ > DATA_W) begin : g_err_irq_width
        $error("rat_io_ctrl: N_IRQ must not exceed DATA_W");
    end
    if (SYNC_STAGES < 2) begin : g_err_sync
        $error("rat_io_ctrl: SYNC_STAGES must be at least 2");
    end

    // -----------------------------------------------------------------------
    // Synchronisers
    // -----------------------------------------------------------------------
    logic [N_IN*DATA_W-1:0] din_sync;
    logic [N_IRQ-1:0]       irq_sync;

    rat_sync #(.WIDTH(N_IN*DATA_W), .STAGES(SYNC_STAGES)) u_sync_din (
        .CLK     (CLK),
        .RESET_N (RESET_N),
        .D       (DEV_IN),
        .Q       (din_sync)
    );

    rat_sync #(.WIDTH(N_IRQ), .STAGES(SYNC_STAGES)) u_sync_irq (
        .CLK     (CLK),
        .RESET_N (RESET_N),
        .D       (IRQ_SRC),
        .Q       (irq_sync)
    );

    // -----------------------------------------------------------------------
    // Write decode
    // -----------------------------------------------------------------------
    logic [N_OUT-1:0] wr_out;
    logic             wr_mask;
    logic             wr_ack;

    always_comb begin
        wr_out = '0;
        for (int k = 0; k < N_OUT; k++) begin
            if (IO_STRB && (PORT_ID == 8'(OUT_BASE + k))) begin
                wr_out[k] = 1'b1;
            end
        end
    end

    assign wr_mask = IO_STRB && (PORT_ID == IRQ_MASK_ID);
    assign wr_ack  = IO_STRB && (PORT_ID == IRQ_ACK_ID);

    // -----------------------------------------------------------------------
    // Output registers
    // -----------------------------------------------------------------------
    logic [N_OUT-1:0][DATA_W-1:0] dev_out_q;
    logic [N_OUT-1:0]             dev_wr_q;

    always_ff @(posedge CLK) begin
        if (!RESET_N) begin
            dev_out_q <= '0;
            dev_wr_q  <= '0;
        end else begin
            dev_wr_q <= wr_out;
            for (int k = 0; k < N_OUT; k++) begin
                if (wr_out[k]) begin
                    dev_out_q[k] <= OUT_PORT;
                end
            end
        end
    end

    assign DEV_OUT = dev_out_q;
    assign DEV_WR  = dev_wr_q;

    // -----------------------------------------------------------------------
    // Interrupt capture: mask, pending, edge detect
    // -----------------------------------------------------------------------
    logic [N_IRQ-1:0] mask_q;
    logic [N_IRQ-1:0] pend_q;
    logic [N_IRQ-1:0] irq_prev_q;
    logic [N_IRQ-1:0] irq_rise;
    logic [N_IRQ-1:0] ack_clr;
    logic [N_IRQ-1:0] mask_nxt;
    logic [N_IRQ-1:0] pend_nxt;
    logic             active;
    logic             active_nxt;

    assign irq_rise = irq_sync & ~irq_prev_q;
    assign ack_clr  = wr_ack ? OUT_PORT[N_IRQ-1:0] : '0;
    assign mask_nxt = wr_mask ? OUT_PORT[N_IRQ-1:0] : mask_q;
    // Clear first, then OR in new edges: a set and an ack of the same bit
    // in one cycle leaves the bit pending.
    assign pend_nxt = (pend_q & ~ack_clr) | irq_rise;

    assign active     = |(pend_q & mask_q);
    assign active_nxt = |(pend_nxt & mask_nxt);

    always_ff @(posedge CLK) begin
        if (!RESET_N) begin
            mask_q     <= '0;
            pend_q     <= '0;
            irq_prev_q <= '0;
        end else begin
            mask_q     <= mask_nxt;
            pend_q     <= pend_nxt;
            irq_prev_q <= irq_sync;
        end
    end

    // -----------------------------------------------------------------------
    // INTERRUPT pulse FSM. int_q is raised on entry to IRQ_FIRE so the
    // pulse coincides exactly with the FIRE cycle.
    // In IRQ_WAIT an ack re-fires only if something is still active after
    // the ack is applied; new sources alone never re-pulse from WAIT.
    // -----------------------------------------------------------------------
    irq_state_t state_q;
    logic       int_q;

    always_ff @(posedge CLK) begin
        if (!RESET_N) begin
            state_q <= IRQ_IDLE;
            int_q   <= 1'b0;
        end else begin
            int_q <= 1'b0;
            case (state_q)
                IRQ_IDLE: begin
                    if (active) begin
                        state_q <= IRQ_FIRE;
                        int_q   <= 1'b1;
                    end
                end
                IRQ_FIRE: begin
                    state_q <= IRQ_WAIT;
                end
                IRQ_WAIT: begin
                    if (wr_ack && active_nxt) begin
                        state_q <= IRQ_FIRE;
                        int_q   <= 1'b1;
                    end else if (!active) begin
                        state_q <= IRQ_IDLE;
                    end
                end
                default: begin
                    state_q <= IRQ_IDLE;
                end
            endcase
        end
    end

    assign INTERRUPT = int_q;
    assign IRQ_STATE = state_q;

    // -----------------------------------------------------------------------
    // Read mux (zero latency)
    // -----------------------------------------------------------------------
    logic [DATA_W-1:0] rd_data;

    always_comb begin
        rd_data = '0;
        for (int k = 0; k < N_IN; k++) begin
            if (PORT_ID == 8'(IN_BASE + k)) begin
                rd_data = din_sync[k*DATA_W +: DATA_W];
            end
        end
        for (int k = 0; k < N_OUT; k++) begin
            if (PORT_ID == 8'(OUT_BASE + k)) begin
                rd_data = dev_out_q[k];
            end
        end
        if (PORT_ID == IRQ_MASK_ID) begin
            rd_data = DATA_W'(mask_q);
        end
        if (PORT_ID == IRQ_PEND_ID) begin
            rd_data = DATA_W'(pend_q);
        end
    end

    assign IN_PORT = rd_data;

endmodule

// File: tb/tb_rat_io_ctrl.sv
// ---------------------------------------------------------------------------
// tb_rat_io_ctrl
// Directed bench for rat_io_ctrl with default parameters. Inputs change 1 ns
// after the rising edge; outputs are read in the same low-risk window or at
// the falling edge. A write scoreboard checks every DEV_WR pulse against an
// expected queue of {index, data} entries.
// ---------------------------------------------------------------------------
module tb_rat_io_ctrl;
    import rat_io_pkg::*;

    // clock / reset ---------------------------------------------------------
    logic        CLK = 1'b0;
    logic        RESET_N;
    logic [7:0]  PORT_ID;
    logic [7:0]  OUT_PORT;
    logic        IO_STRB;
    logic [7:0]  IN_PORT;
    logic [31:0] DEV_IN;
    logic [31:0] DEV_OUT;
    logic [3:0]  DEV_WR;
    logic [3:0]  IRQ_SRC;
    logic        INTERRUPT;
    irq_state_t  IRQ_STATE;

    always #5 CLK = ~CLK;

    rat_io_ctrl dut (
        .CLK       (CLK),
        .RESET_N   (RESET_N),
        .PORT_ID   (PORT_ID),
        .OUT_PORT  (OUT_PORT),
        .IO_STRB   (IO_STRB),
        .IN_PORT   (IN_PORT),
        .DEV_IN    (DEV_IN),
        .DEV_OUT   (DEV_OUT),
        .DEV_WR    (DEV_WR),
        .IRQ_SRC   (IRQ_SRC),
        .INTERRUPT (INTERRUPT),
        .IRQ_STATE (IRQ_STATE)
    );

    // counters / scoreboard ------------------------------------------------
    int          checks     = 0;
    int          errors     = 0;
    int          irq_pulses = 0;
    logic [11:0] exp_q[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Every DEV_WR pulse must match the next queued {index, data} write.
    always @(negedge CLK) begin
        if (RESET_N === 1'b1 && DEV_WR != 4'b0) begin
            for (int k = 0; k < 4; k++) begin
                if (DEV_WR[k]) begin
                    if (exp_q.size() == 0) begin
                        check("wr_unexpected", {20'b0, 4'(k), DEV_OUT[k*8 +: 8]}, 32'b0);
                    end else begin
                        check("wr_scoreboard", {20'b0, 4'(k), DEV_OUT[k*8 +: 8]},
                              {20'b0, exp_q.pop_front()});
                    end
                end
            end
        end
        if (INTERRUPT === 1'b1) irq_pulses++;
    end

    // driver tasks ----------------------------------------------------------
    task automatic step(input int n);
        repeat (n) begin
            @(posedge CLK);
            #1;
        end
    endtask

    task automatic wr(input logic [7:0] id, input logic [7:0] d);
        PORT_ID  = id;
        OUT_PORT = d;
        IO_STRB  = 1'b1;
        @(posedge CLK);
        #1;
        IO_STRB  = 1'b0;
    endtask

    task automatic rd(input string tag, input logic [7:0] id, input logic [7:0] exp);
        PORT_ID = id;
        #1;
        check(tag, {24'b0, IN_PORT}, {24'b0, exp});
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    int p0;

    initial begin
        RESET_N  = 1'b0;
        PORT_ID  = 8'h00;
        OUT_PORT = 8'h00;
        IO_STRB  = 1'b0;
        DEV_IN   = 32'h0;
        IRQ_SRC  = 4'h0;
        step(3);

        // reset state
        check("rst_dev_out", DEV_OUT, 32'h0);
        check("rst_dev_wr", {28'b0, DEV_WR}, 32'h0);
        check("rst_int", {31'b0, INTERRUPT}, 32'h0);
        check("rst_state", 32'(IRQ_STATE), 32'(IRQ_IDLE));
        rd("rst_pend", 8'hF1, 8'h00);
        RESET_N = 1'b1;
        step(1);

        // 1: output register write, pulse, readback
        exp_q.push_back({4'd1, 8'hA5});
        wr(8'h41, 8'hA5);
        check("t1_dev_wr", {28'b0, DEV_WR}, 32'h2);
        check("t1_dev_out", DEV_OUT, 32'h0000_A500);
        step(1);
        check("t1_dev_wr_gone", {28'b0, DEV_WR}, 32'h0);
        rd("t1_rd41", 8'h41, 8'hA5);
        rd("t1_rd40", 8'h40, 8'h00);
        wr(8'h99, 8'hFF);
        check("unmapped_wr", {28'b0, DEV_WR}, 32'h0);
        check("unmapped_out", DEV_OUT, 32'h0000_A500);
        rd("unmapped_rd", 8'h99, 8'h00);
        exp_q.push_back({4'd3, 8'h5A});
        wr(8'h43, 8'h5A);
        check("wr43_dev_wr", {28'b0, DEV_WR}, 32'h8);
        step(1);

        // 2: input synchroniser latency
        DEV_IN = 32'h00C3_003C;
        rd("t2_t0", 8'h20, 8'h00);
        step(1);
        rd("t2_t1", 8'h20, 8'h00);
        step(1);
        rd("t2_t2", 8'h20, 8'h3C);
        rd("t2_port2", 8'h22, 8'hC3);
        rd("t2_port1", 8'h21, 8'h00);

        // mask register, bits above N_IRQ dropped
        wr(8'hF0, 8'hFF);
        rd("mask_ff", 8'hF0, 8'h0F);
        wr(8'hF0, 8'h01);
        rd("mask_01", 8'hF0, 8'h01);

        // 3: single pulse while source held
        p0 = irq_pulses;
        IRQ_SRC = 4'b0001;
        step(2);
        rd("t3_pend_early", 8'hF1, 8'h00);
        step(1);
        rd("t3_pend", 8'hF1, 8'h01);
        step(1);
        check("t3_int", {31'b0, INTERRUPT}, 32'h1);
        check("t3_fire", 32'(IRQ_STATE), 32'(IRQ_FIRE));
        step(1);
        check("t3_int_low", {31'b0, INTERRUPT}, 32'h0);
        step(10);
        check("t3_one_pulse", 32'(irq_pulses - p0), 32'h1);
        check("t3_wait", 32'(IRQ_STATE), 32'(IRQ_WAIT));
        IRQ_SRC = 4'b0000;
        wr(8'hF2, 8'h01);
        step(1);
        check("t3_idle", 32'(IRQ_STATE), 32'(IRQ_IDLE));

        // 4: ack leaving another active source re-pulses
        wr(8'hF0, 8'h03);
        IRQ_SRC = 4'b0011;
        step(3);
        rd("t4_pend", 8'hF1, 8'h03);
        step(2);
        check("t4_wait", 32'(IRQ_STATE), 32'(IRQ_WAIT));
        IRQ_SRC = 4'b0000;
        p0 = irq_pulses;
        wr(8'hF2, 8'h01);
        check("t4_repulse", {31'b0, INTERRUPT}, 32'h1);
        rd("t4_pend_after", 8'hF1, 8'h02);
        step(1);
        check("t4_one_repulse", 32'(irq_pulses - p0), 32'h1);
        wr(8'hF2, 8'h02);
        check("t4_no_pulse", {31'b0, INTERRUPT}, 32'h0);
        step(1);
        check("t4_idle", 32'(IRQ_STATE), 32'(IRQ_IDLE));
        step(2);
        check("t4_no_extra", 32'(irq_pulses - p0), 32'h1);

        // 5: set beats ack in the same cycle
        wr(8'hF0, 8'h00);
        IRQ_SRC = 4'b0100;
        step(3);
        IRQ_SRC = 4'b0000;
        step(3);
        rd("t5_primed", 8'hF1, 8'h04);
        IRQ_SRC = 4'b0100;
        step(2);
        wr(8'hF2, 8'h04);
        rd("t5_set_wins", 8'hF1, 8'h04);
        step(1);
        wr(8'hF2, 8'h04);
        rd("t5_ack_clears", 8'hF1, 8'h00);

        // 6: reset during a write with pending set
        IRQ_SRC = 4'b1000;
        step(3);
        rd("t6_pend_pre", 8'hF1, 8'h08);
        wr(8'hF0, 8'h08);
        RESET_N  = 1'b0;
        PORT_ID  = 8'h40;
        OUT_PORT = 8'hFF;
        IO_STRB  = 1'b1;
        step(1);
        IO_STRB  = 1'b0;
        check("t6_dev_wr", {28'b0, DEV_WR}, 32'h0);
        check("t6_dev_out", DEV_OUT, 32'h0);
        check("t6_int", {31'b0, INTERRUPT}, 32'h0);
        check("t6_state", 32'(IRQ_STATE), 32'(IRQ_IDLE));
        rd("t6_pend", 8'hF1, 8'h00);
        rd("t6_mask", 8'hF0, 8'h00);
        rd("t6_din", 8'h20, 8'h00);

        // source held through reset release is a fresh edge
        RESET_N = 1'b1;
        step(2);
        rd("rel_pend_early", 8'hF1, 8'h00);
        step(1);
        rd("rel_pend", 8'hF1, 8'h08);
        step(2);

        check("sb_drained", 32'(exp_q.size()), 32'h0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
